scsi_fifo_ctrl: RTL
===================

Name: scsi_fifo_ctrl

Overview:
- Pointer, flag and flush controller for the longword DMA FIFO that sits between the SCSI transfer state machine and the host bus.
- Consumes the transfer engine's INCBO/INCNI/INCNO strobes and produces the next-in, next-out and byte-lane pointers, plus BOEQ3, FIFOFULL and FIFOEMPTY.
- Sequences end-of-transfer flushes: commits a partial longword (SCSI->FIFO) or discards residue (FIFO->SCSI).
- Owns sticky overflow/underflow error flags.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO depth in longwords (default 8 entries).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- INCBO  in  1  advance byte pointer
- INCNI  in  1  advance next-in pointer (longword written)
- INCNO  in  1  advance next-out pointer (longword read)
- DMADIR  in  1  1 = SCSI->FIFO, 0 = FIFO->SCSI
- FIFO_CLR  in  1  software clear of pointers, flags and errors
- FLUSH  in  1  end-of-transfer flush request (level; sampled in IDLE)
- NI  out  DEPTH_LOG2  next-in index
- NO  out  DEPTH_LOG2  next-out index
- BO  out  2  byte-lane pointer
- BOEQ3  out  1  BO == 3
- FIFOFULL  out  1  CNT == 2^DEPTH_LOG2
- FIFOEMPTY  out  1  CNT == 0
- CNT  out  DEPTH_LOG2+1  occupied longwords
- FLUSH_BUSY  out  1  flush sequencer not IDLE
- FLUSH_DONE  out  1  one-cycle pulse at flush completion
- OVF  out  1  sticky: INCNI while full without INCNO
- UNF  out  1  sticky: INCNO while empty

Behaviour:
- Reset (RESET=1 at CLK edge): NI=NO=0, BO=0, CNT=0, OVF=UNF=0, sequencer IDLE, FLUSH_DONE=0. After reset: FIFOEMPTY=1, FIFOFULL=0, BOEQ3=0.
- FIFO_CLR has the same effect as RESET on all state. It takes priority over the strobes and over flush in that cycle.
- Registered state (all updated on the CLK edge): NI, NO, BO, CNT, OVF, UNF, sequencer state.
- Combinational outputs: BOEQ3, FIFOFULL, FIFOEMPTY, FLUSH_BUSY (derived from registered state). FLUSH_DONE is registered.
- NI and NO wrap modulo 2^DEPTH_LOG2. BO wraps 3->0. No carry from BO into NI/NO; the engine strobes those explicitly.
- Effective INCNI:
  - Ignored when full unless INCNO is asserted in the same cycle.
  - An ignored INCNI sets OVF and leaves NI unchanged.
- Effective INCNO:
  - Ignored when empty, which sets UNF.
  - INCNI+INCNO both asserted while empty: INCNO is ignored (sets UNF) and INCNI applies, so CNT becomes 1.
- CNT: +1 on effective INCNI only, -1 on effective INCNO only, unchanged when both are effective. Full plus simultaneous INCNI+INCNO is legal: CNT stays full and both pointers advance.
- DMADIR change: on any cycle where DMADIR differs from its registered copy, BO clears to 0. NI, NO and CNT are kept.
- Flush sequencer states: IDLE, WAIT_SPACE, COMMIT, DONE.
  - IDLE:
    - FLUSH=1 and BO==0 -> DONE.
    - FLUSH=1, BO!=0, DMADIR=1 -> FIFOFULL ? WAIT_SPACE : COMMIT.
    - FLUSH=1, BO!=0, DMADIR=0 -> DONE; BO cleared (residue discarded).
  - WAIT_SPACE: stay while FIFOFULL; -> COMMIT when not full.
  - COMMIT:
    - Generates an internal INCNI (same rules as external INCNI; OR-combined with it, counted once) and clears BO.
    - If an external INCNO occurs in the same cycle it applies normally. -> DONE.
  - DONE: FLUSH_DONE=1 for exactly this cycle. -> IDLE.
  - FLUSH_BUSY = state != IDLE.
- External INCBO during WAIT_SPACE/COMMIT is ignored. External INCNI/INCNO remain honoured in all states.
- FIFO_CLR or RESET mid-flush: sequencer returns to IDLE, no FLUSH_DONE pulse.
- Latency:
  - Strobe to pointer/flag update: 1 cycle.
  - Flush with space available: FLUSH sampled -> COMMIT next cycle -> FLUSH_DONE the cycle after.

Test Plan:
- Reset then 8x INCNI (DEPTH_LOG2=3) -> CNT 0..8, NI wraps to 0, FIFOFULL=1 after 8th. 9th INCNI -> OVF=1, NI=0, CNT=8.
- Full FIFO, INCNI+INCNO same cycle -> CNT=8, NI=1, NO=1, no OVF. Then 8x INCNO -> FIFOEMPTY=1. Extra INCNO -> UNF=1, NO unchanged.
- 4x INCBO -> BO 1,2,3(BOEQ3=1),0. Toggle DMADIR at BO=2 -> BO=0 next cycle.
- DMADIR=1, BO=2, CNT=3, FLUSH -> COMMIT next cycle, CNT=4, BO=0, FLUSH_DONE pulse one cycle later. Repeat with CNT=8 -> waits in WAIT_SPACE until an INCNO, then commits.
- DMADIR=0, BO=1, FLUSH -> BO=0, CNT unchanged, FLUSH_DONE 1 cycle later. FLUSH with BO=0 -> DONE without pointer change.
- Assert FIFO_CLR while in WAIT_SPACE with OVF=1 -> all pointers 0, OVF=0, FLUSH_BUSY=0, no FLUSH_DONE.

Source files
------------

// File: rtl/scsi_fifo_ctrl_if.sv
// Handshake bundle between the SCSI transfer engine (master) and the
// DMA FIFO pointer/flag/flush controller (slave).
interface scsi_fifo_ctrl_if #(
    parameter int DEPTH_LOG2 = 3
);
    // Engine -> controller strobes and controls
    logic                  INCBO;
    logic                  INCNI;
    logic                  INCNO;
    logic                  DMADIR;
    logic                  FIFO_CLR;
    logic                  FLUSH;

    // Controller -> engine pointers and flags
    logic [DEPTH_LOG2-1:0] NI;
    logic [DEPTH_LOG2-1:0] NO;
    logic [1:0]            BO;
    logic                  BOEQ3;
    logic                  FIFOFULL;
    logic                  FIFOEMPTY;
    logic [DEPTH_LOG2:0]   CNT;
    logic                  FLUSH_BUSY;
    logic                  FLUSH_DONE;
    logic                  OVF;
    logic                  UNF;

    modport master (
        output INCBO, INCNI, INCNO, DMADIR, FIFO_CLR, FLUSH,
        input  NI, NO, BO, BOEQ3, FIFOFULL, FIFOEMPTY, CNT,
               FLUSH_BUSY, FLUSH_DONE, OVF, UNF
    );

    modport slave (
        input  INCBO, INCNI, INCNO, DMADIR, FIFO_CLR, FLUSH,
        output NI, NO, BO, BOEQ3, FIFOFULL, FIFOEMPTY, CNT,
               FLUSH_BUSY, FLUSH_DONE, OVF, UNF
    );
endinterface

// File: rtl/scsi_fifo_ctrl.sv
// Pointer, flag and flush controller for the longword DMA FIFO between the
// SCSI transfer state machine and the host bus. Tracks next-in/next-out
// longword indices, the byte-lane pointer, occupancy, sticky over/underflow,
// and sequences end-of-transfer flushes (commit partial longword when
// SCSI->FIFO, discard residue when FIFO->SCSI).
module scsi_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    scsi_fifo_ctrl_if.slave  bus
);

    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_COMMIT,
        ST_DONE
    } state_e;

    state_e                state_q;
    logic                  done_q;
    logic [DEPTH_LOG2-1:0] ni_q, ni_d;
    logic [DEPTH_LOG2-1:0] no_q, no_d;
    logic [1:0]            bo_q, bo_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  dir_q;

    logic full, empty;
    logic clr;
    logic commit;
    logic ni_req, ni_eff, no_eff;
    logic discard;
    logic bo_hold;

    assign full   = (cnt_q == FULL_CNT);
    assign empty  = (cnt_q == '0);
    assign clr    = RESET || bus.FIFO_CLR;
    assign commit = (state_q == ST_COMMIT);

    // The flush commit is an INCNI in its own right; OR-ing it with the
    // external strobe makes a coincident pair count as a single longword.
    assign ni_req  = bus.INCNI || commit;
    // A full FIFO still accepts a write when a read frees a slot this cycle.
    assign ni_eff  = ni_req && (!full || bus.INCNO);
    assign no_eff  = bus.INCNO && !empty;
    // FIFO->SCSI flush with bytes pending: the partial longword is dropped.
    assign discard = (state_q == ST_IDLE) && bus.FLUSH && (bo_q != 2'd0) && !bus.DMADIR;
    // The byte lane is frozen while a commit is pending or in progress.
    assign bo_hold = (state_q == ST_WAIT_SPACE) || commit;

    // Next-state for pointers, occupancy and sticky error flags
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        ni_d  = ni_q;
        no_d  = no_q;
        bo_d  = bo_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;

        if (ni_eff) ni_d = ni_q + DEPTH_LOG2'(1);
        if (no_eff) no_d = no_q + DEPTH_LOG2'(1);

        if (ni_eff && !no_eff)      cnt_d = cnt_q + 1'b1;
        else if (no_eff && !ni_eff) cnt_d = cnt_q - 1'b1;

        if (ni_req && full && !bus.INCNO) ovf_d = 1'b1;
        if (bus.INCNO && empty)           unf_d = 1'b1;

        if (bus.DMADIR != dir_q || commit || discard) bo_d = 2'd0;
        else if (bus.INCBO && !bo_hold)               bo_d = bo_q + 2'd1;
    end

    // Datapath registers; FIFO_CLR acts exactly like reset
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous here, so it is simply the highest-priority branch of the clocked block.
        if (clr) begin
            ni_q  <= '0;
            no_q  <= '0;
            bo_q  <= 2'd0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            // Track the live direction so leaving clear does not look like a flip.
            dir_q <= bus.DMADIR;
        end else begin
            ni_q  <= ni_d;
            no_q  <= no_d;
            bo_q  <= bo_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            dir_q <= bus.DMADIR;
        end
    end

    // Flush sequencer with registered one-cycle FLUSH_DONE (high while in DONE)
    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.FLUSH) begin
                        if (bo_q != 2'd0 && bus.DMADIR) begin
                            state_q <= full ? ST_WAIT_SPACE : ST_COMMIT;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WAIT_SPACE: begin
                    if (!full) state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.NI         = ni_q;
    assign bus.NO         = no_q;
    assign bus.BO         = bo_q;
    assign bus.CNT        = cnt_q;
    assign bus.OVF        = ovf_q;
    assign bus.UNF        = unf_q;
    assign bus.BOEQ3      = (bo_q == 2'd3);
    assign bus.FIFOFULL   = full;
    assign bus.FIFOEMPTY  = empty;
    assign bus.FLUSH_BUSY = (state_q != ST_IDLE);
    assign bus.FLUSH_DONE = done_q;

endmodule
